// File: rtl/multiplier_pkg.sv
// Shared types for the sequential shift-and-add multiplier: FSM state encoding
// and the iteration-counter width helper.
package multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must be able to hold BITS itself, hence BITS+1 codes.
    function automatic int counter_width(input int bits);
        return $clog2(bits + 1);
    endfunction

endpackage

// File: rtl/shift_add_datapath.sv
// Operand shift registers, accumulator and add/subtract unit of the multiplier.
// With MULTIPLIER_SIGNED_EN the final iteration subtracts for signed operands.
module shift_add_datapath
    import multiplier_pkg::*;
#(
    parameter int BITS = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic                step,
    input  logic                last,
`ifdef MULTIPLIER_SIGNED_EN
    input  logic                signed_mode,
`endif
    input  logic [BITS-1:0]     multiplicand,
    input  logic [BITS-1:0]     multiplier,
    output logic [2*BITS-1:0]   sum
);

    logic [2*BITS-1:0] mcand;
    logic [BITS-1:0]   mplier;
    logic [2*BITS-1:0] acc;
`ifdef MULTIPLIER_SIGNED_EN
    logic              signed_q;
`endif

    always_comb begin
        sum = mplier[0] ? (acc + mcand) : acc;
`ifdef MULTIPLIER_SIGNED_EN
        // The multiplier MSB carries weight -2^(BITS-1) in two's complement.
        if (signed_q && last && mplier[0])
            sum = acc - mcand;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
`ifdef MULTIPLIER_SIGNED_EN
            signed_q <= 1'b0;
`endif
        end else if (load) begin
`ifdef MULTIPLIER_SIGNED_EN
            mcand    <= signed_mode ? {{BITS{multiplicand[BITS-1]}}, multiplicand}
                                    : {{BITS{1'b0}}, multiplicand};
            signed_q <= signed_mode;
`else
            mcand    <= {{BITS{1'b0}}, multiplicand};
`endif
            mplier   <= multiplier;
            acc      <= '0;
        end else if (step) begin
            acc      <= sum;
            mcand    <= mcand << 1;
            mplier   <= mplier >> 1;
        end
    end

`ifndef MULTIPLIER_SIGNED_EN
    logic unused_last;
    assign unused_last = last;
`endif

endmodule

// File: rtl/shift_add_multiplier.sv
// Multi-cycle shift-and-add multiply unit: start/ready handshake, one multiplier
// bit per clock, registered 2*BITS product. MULTIPLIER_SIGNED_EN adds i_signed.
module shift_add_multiplier
    import multiplier_pkg::*;
#(
    parameter int BITS = 8
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_start,
    output logic                o_ready,
    output logic                o_finished,
    input  logic [BITS-1:0]     i_multiplicand,
    input  logic [BITS-1:0]     i_multiplier,
`ifdef MULTIPLIER_SIGNED_EN
    input  logic                i_signed,
`endif
    output logic [2*BITS-1:0]   o_product
);

    localparam int CW = counter_width(BITS);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              load;
    logic              step;
    logic              last;
    logic [2*BITS-1:0] sum;

    assign load = (state == IDLE) && i_start;
    assign step = (state == RUN);
    assign last = step && (cnt == CW'(BITS - 1));

    shift_add_datapath #(
        .BITS(BITS)
    ) u_datapath (
        .clock        (i_clock),
        .reset        (i_reset),
        .load         (load),
        .step         (step),
        .last         (last),
`ifdef MULTIPLIER_SIGNED_EN
        .signed_mode  (i_signed),
`endif
        .multiplicand (i_multiplicand),
        .multiplier   (i_multiplier),
        .sum          (sum)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state      <= IDLE;
            cnt        <= '0;
            o_ready    <= 1'b1;
            o_finished <= 1'b0;
            o_product  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state   <= RUN;
                        cnt     <= '0;
                        o_ready <= 1'b0;
                    end
                end
                RUN: begin
                    cnt <= cnt + CW'(1);
                    // Final iteration: publish the product as DONE is entered.
                    if (last) begin
                        state      <= DONE;
                        o_finished <= 1'b1;
                        o_product  <= sum;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    o_finished <= 1'b0;
                    o_ready    <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    o_finished <= 1'b0;
                    o_ready    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Parametrised sequential shift-and-add multiplier producing the full double-width product of two BITS-wide operands, one multiplier bit per clock. It adds a start/ready handshake, a registered product output and an optional two's-complement mode. It sits beside the ALU as the multi-cycle multiply unit.

## Interface

- BITS, 8, operand width; legal range 2..32; product width is 2*BITS.
- i_clock  input  1  rising-edge clock.
- i_reset  input  1  asynchronous, active-high reset.
- i_start  input  1  request; accepted only on an edge where o_ready=1.
- o_ready  output  1  high in IDLE; the unit can accept i_start.
- o_finished  output  1  single-cycle pulse; o_product is valid from this cycle on.
- i_multiplicand  input  BITS  operand A; sampled on the accepting edge.
- i_multiplier  input  BITS  operand B; sampled on the accepting edge.
- i_signed  input  1  present only with MULTIPLIER_SIGNED_EN; sampled on the accepting edge.
- o_product  output  2*BITS  registered A*B; held until the next accepted start.

## Operation

- FSM states:
  - IDLE: o_ready=1.
  - RUN: iterate; o_ready=0.
  - DONE: o_finished=1; o_ready=0.
- IDLE -> RUN: on an edge with i_start=1.
  - Load the multiplicand shift register (2*BITS wide, zero-extended; sign-extended in signed mode).
  - Load the multiplier shift register (BITS).
  - Clear the accumulator (2*BITS) and the iteration counter (width $clog2(BITS+1)).
- RUN, each edge:
  - If the multiplier LSB is 1, accumulator += multiplicand. All arithmetic is modulo 2^(2*BITS).
  - Shift the multiplicand left 1 (zero fill) and the multiplier right 1 (zero fill).
  - Increment the counter.
- RUN -> DONE: on the edge that performs iteration BITS. That edge also loads o_product with the final accumulator value.
- DONE -> IDLE: unconditionally on the next edge.
- i_start while o_ready=0: ignored, with no effect on in-flight operands.
- Operand inputs may change freely after the accepting edge.
- Operand of 0: still takes the full BITS iterations, with no early exit. Result is 0.

## Timing

- Reset values (asynchronous): state=IDLE, o_ready=1, o_finished=0, o_product=0. Internal registers are also cleared.
- The accepting edge is E0. Iterations run on E1..EBITS.
- o_finished=1 and the new o_product are visible in the cycle after EBITS, i.e. BITS cycles after E0.
- The unit returns to IDLE at EBITS+1. A new start can be accepted at EBITS+2 at the earliest.
- Throughput: one product per BITS+2 cycles.
- o_ready is low from E0 through EBITS+1.
- o_product keeps the previous result during RUN. It changes only on the DONE-entering edge or on reset.
- Reset asserted mid-RUN or in DONE: the operation is aborted and no o_finished pulse occurs.
- Reset released: the first accept is possible on the next edge with i_start=1.

## Configuration

- MULTIPLIER_SIGNED_EN defined:
  - The i_signed port exists.
  - When i_signed=1 at accept, the multiplicand is sign-extended to 2*BITS.
  - On the final iteration (multiplier MSB) the accumulator subtracts the multiplicand instead of adding it.
  - The result is the exact two's-complement product.
  - When i_signed=0, behaviour is identical to unsigned.
- MULTIPLIER_SIGNED_EN undefined:
  - No i_signed port.
  - Unsigned only; no subtract path is synthesised.
- Latency is identical in both builds.

## Structure

- Shared package multiplier_pkg holds:
  - the FSM state typedef (IDLE, RUN, DONE);
  - the localparam function for the counter width.
- One sub-module is natural: shift_add_datapath. It contains the operand shift registers, the accumulator and the add/subtract unit, controlled by load/step/last strobes from the FSM in shift_add_multiplier.

## Test plan

- Unsigned, BITS=8: A=13, B=11 -> o_finished 8 cycles after accept, o_product=0x008F. A=255, B=255 -> 0xFE01.
- Zero operand: A=0, B=0xA5 -> 0x0000 after the full 8-cycle latency. o_ready returns high at E9.
- Busy: pulse i_start with A=2, B=3 at E3 of a 13*11 run -> ignored. The result is still 0x008F and only one o_finished pulse occurs.
- Back-to-back: hold i_start=1 with changing operands -> accepts at E0, E10, E20. Each product is correct and o_product is stable between pulses.
- Reset at E4 of a run -> o_ready=1, o_product=0, o_finished=0 immediately (asynchronous). No late pulse follows.
- Signed (MULTIPLIER_SIGNED_EN, i_signed=1):
  - -3 (0xFD) * 5 -> 0xFFF1.
  - -128 * -128 -> 0x4000.
  - The same operands with i_signed=0: 0xFD*5 -> 0x04F1.
